// File: rtl/xoodyak_pkg.sv
// Shared types for the Xoodyak command sequencer: core opmodes and sequencer FSM states.
package xoodyak_pkg;

  typedef enum logic [3:0] {
    OP_IDLE    = 4'd0,
    OP_INIT    = 4'd1,
    OP_NONCE   = 4'd2,
    OP_ASSOC   = 4'd3,
    OP_CRYPT   = 4'd4,
    OP_DECRYPT = 4'd5,
    OP_SQUEEZE = 4'd6,
    OP_RATCHET = 4'd7
  } opmode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ADV,
    S_ERR
  } state_e;

endpackage

// File: rtl/xoodyak_cmd_seq_if.sv
// Command handshake between the sequencer (master) and the Xoodyak core (slave).
interface xoodyak_cmd_seq_if;
  logic       core_start;
  logic [3:0] core_opmode;
  logic       core_finished;

  modport master (output core_start, output core_opmode, input core_finished);
  modport slave  (input core_start, input core_opmode, output core_finished);
endinterface

// File: rtl/xoodyak_seq_slots.sv
// Command slot register file: one write port, three asynchronous read ports
// (current slot, next slot opmode, slot 0 opmode).
module xoodyak_seq_slots #(
  parameter int DEPTH = 16,
  parameter int CW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          eph1,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wop,
  input  logic [CW-1:0] wcnt,
  input  logic [AW-1:0] raddr,
  output logic [3:0]    rop,
  output logic [CW-1:0] rcnt,
  input  logic [AW-1:0] naddr,
  output logic [3:0]    nop,
  output logic [3:0]    op0
);

  logic [3:0]    op_mem  [DEPTH];
  logic [CW-1:0] cnt_mem [DEPTH];

  // NOTE: the slot array is reset explicitly because an all-zero table means an empty list after reset.
  always_ff @(posedge eph1) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_mem[i]  <= '0;
        cnt_mem[i] <= '0;
      end
    end else if (we) begin
      op_mem[waddr]  <= wop;
      cnt_mem[waddr] <= wcnt;
    end
  end

  assign rop  = op_mem[raddr];
  assign rcnt = cnt_mem[raddr];
  assign nop  = op_mem[naddr];
  assign op0  = op_mem[0];

endmodule

// File: rtl/xoodyak_cmd_seq.sv
// Xoodyak command sequencer: walks a programmed slot list, issuing each opmode
// count+1 times to the core, with looping, abort and a per-command timeout.
module xoodyak_cmd_seq #(
  parameter int DEPTH = 16,
  parameter int CW    = 8,
  parameter int TMO   = 1023
) (
  input  logic                     eph1,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [3:0]               cfg_opmode,
  input  logic [CW-1:0]            cfg_count,
  input  logic                     go,
  input  logic                     abort,
  input  logic                     loop_en,
  xoodyak_cmd_seq_if.master        core,
  output logic                     busy,
  output logic                     seq_done,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH)-1:0] cur_slot,
  output logic [15:0]              issue_cnt
);
  import xoodyak_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cur_slot_d, nxt_slot;
  logic [15:0]   issue_cnt_d;
  logic [CW-1:0] rep_q, rep_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          first_q, first_d;
  logic          done_d, terr_d;
  logic          wr_en;
  logic [3:0]    cur_op, nxt_op, op0;
  logic [CW-1:0] cur_cnt;

  assign wr_en    = cfg_we && (state_q == S_IDLE);
  assign nxt_slot = cur_slot + 1'b1;

  xoodyak_seq_slots #(.DEPTH(DEPTH), .CW(CW), .AW(AW)) u_slots (
    .eph1  (eph1),
    .reset (reset),
    .we    (wr_en),
    .waddr (cfg_addr),
    .wop   (cfg_opmode),
    .wcnt  (cfg_count),
    .raddr (cur_slot),
    .rop   (cur_op),
    .rcnt  (cur_cnt),
    .naddr (nxt_slot),
    .nop   (nxt_op),
    .op0   (op0)
  );

  // first_q marks that the next ISSUE is the slot's first, so rep_ctr is loaded there.
  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cur_slot_d  = cur_slot;
    issue_cnt_d = issue_cnt;
    rep_d       = rep_q;
    tmo_d       = tmo_q;
    first_d     = first_q;
    done_d      = 1'b0;
    terr_d      = timeout_err;
    if (abort) begin
      state_d = S_IDLE;
      terr_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (go) begin
          cur_slot_d  = '0;
          issue_cnt_d = '0;
          first_d     = 1'b1;
          if (op0 != OP_IDLE) state_d = S_ISSUE;
          else                done_d  = 1'b1;
        end
        S_ISSUE: begin
          issue_cnt_d = issue_cnt + 16'd1;
          if (first_q) rep_d = cur_cnt;
          first_d = 1'b0;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (core.core_finished) begin
            if (rep_q != '0) begin
              rep_d   = rep_q - 1'b1;
              state_d = S_ISSUE;
            end else begin
              state_d = S_ADV;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_d = S_ERR;
            terr_d  = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        S_ADV: begin
          first_d = 1'b1;
          if (cur_slot == AW'(DEPTH - 1) || nxt_op == OP_IDLE) begin
            if (loop_en && op0 != OP_IDLE) begin
              cur_slot_d = '0;
              state_d    = S_ISSUE;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            cur_slot_d = nxt_slot;
            state_d    = S_ISSUE;
          end
        end
        S_ERR:   ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge eph1) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_slot    <= '0;
      issue_cnt   <= '0;
      rep_q       <= '0;
      tmo_q       <= '0;
      first_q     <= 1'b0;
      seq_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_slot    <= cur_slot_d;
      issue_cnt   <= issue_cnt_d;
      rep_q       <= rep_d;
      tmo_q       <= tmo_d;
      first_q     <= first_d;
      seq_done    <= done_d;
      timeout_err <= terr_d;
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign core.core_start  = (state_q == S_ISSUE);
  assign core.core_opmode = (state_q == S_ISSUE || state_q == S_WAIT) ? cur_op : 4'd0;

endmodule
